// File: rtl/flux_tag_arbiter_pkg.sv
// flux_tag_arbiter_pkg
// Shared definitions for the tagged-flux arbiter and the shared FIFO it feeds.
// A FIFO word carries the flux tag in its top TAG_WIDTH bits and the payload
// in the low DW bits. The helpers work on a wide carrier type so that the
// arbiter and the FIFO can use them for any word width up to MAX_WORD_W.
package flux_tag_arbiter_pkg;

  localparam int MAX_WORD_W = 64;

  typedef logic [MAX_WORD_W-1:0] word_t;

  // Tag field width for a given number of fluxes (at least one bit).
  function automatic int tag_width_of(input int flux);
    int tw;
    if (flux > 32'sd1) begin
      tw = $clog2(flux);
    end else begin
      tw = 32'sd1;
    end
    return tw;
  endfunction

  // Payload width once the tag field has been carved out of the word.
  function automatic int data_width_of(input int width, input int flux);
    return width - tag_width_of(flux);
  endfunction

  // Build a word: tag placed directly above the payload field.
  function automatic word_t tag_insert(input word_t payload, input word_t tag,
                                       input int dw, input int tag_w);
    word_t dmask;
    word_t tmask;
    dmask = (word_t'(1'b1) << dw) - word_t'(1'b1);
    tmask = (word_t'(1'b1) << tag_w) - word_t'(1'b1);
    return ((tag & tmask) << dw) | (payload & dmask);
  endfunction

  // Recover the tag from a word built by tag_insert.
  function automatic word_t tag_extract(input word_t word, input int dw,
                                        input int tag_w);
    word_t tmask;
    tmask = (word_t'(1'b1) << tag_w) - word_t'(1'b1);
    return (word >> dw) & tmask;
  endfunction

endpackage

// File: rtl/flux_tag_arbiter_rr_grant.sv
// rr_grant
// Combinational round-robin search. Starting at last+1 and wrapping, the
// first asserted request bit wins.
//   request   : per-source request vector
//   last      : index of the most recent winner
//   grant     : one-hot winner, zero when nothing requests
//   grant_idx : binary index of the winner (0 when nothing requests)
module rr_grant
  import flux_tag_arbiter_pkg::*;
#(
  parameter int FLUX      = 2,
  parameter int TAG_WIDTH = 1
) (
  input  logic [FLUX-1:0]      request,
  input  logic [TAG_WIDTH-1:0] last,
  output logic [FLUX-1:0]      grant,
  output logic [TAG_WIDTH-1:0] grant_idx
);

  // Wrap-around priority search beginning just after the previous winner
  always_comb begin
    int   idx_v;
    logic found_v;
    grant     = '0;
    grant_idx = '0;
    found_v   = 1'b0;
    idx_v     = 32'sd0;
    for (int k = 1; k <= FLUX; k++) begin
      idx_v = (int'(last) + k) % FLUX;
      if (!found_v && request[idx_v]) begin
        found_v      = 1'b1;
        grant[idx_v] = 1'b1;
        grant_idx    = TAG_WIDTH'(idx_v);
      end else begin
        found_v = found_v;
      end
    end
  end

endmodule

// File: rtl/flux_tag_arbiter.sv
// flux_tag_arbiter
// Merges FLUX source streams into one shared FIFO through a single output
// register, tagging each word with its source index. A per-flux occupancy
// counter tracks how many words of each flux sit in the FIFO and stops a
// flux from exceeding QUOTA resident words.
//   ck       : clock, rising edge
//   rst      : asynchronous active-high reset (issued with the FIFO reset)
//   in_data  : source payloads, source i at [i*DW +: DW]
//   in_valid : source i offers a word
//   in_ready : source i word accepted this cycle (one-hot or zero)
//   full     : shared FIFO full flag
//   empty    : per-flux FIFO empty flags
//   rd       : per-flux FIFO read strobes (observed only)
//   wr       : FIFO write strobe
//   dataout  : FIFO write word {tag, payload}
module flux_tag_arbiter
  import flux_tag_arbiter_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int FLUX      = 2,
  parameter  int QUOTA     = 8,
  localparam int TAG_WIDTH = tag_width_of(FLUX),
  localparam int DW        = data_width_of(WIDTH, FLUX),
  localparam int OCC_W     = $clog2(QUOTA + 1)
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic [FLUX*DW-1:0]   in_data,
  input  logic [FLUX-1:0]      in_valid,
  output logic [FLUX-1:0]      in_ready,
  input  logic                 full,
  input  logic [FLUX-1:0]      empty,
  input  logic [FLUX-1:0]      rd,
  output logic                 wr,
  output logic [WIDTH-1:0]     dataout
);

  logic                 out_valid_r;
  logic [WIDTH-1:0]     out_data_r;
  logic [TAG_WIDTH-1:0] rr_ptr_r;
  logic [OCC_W-1:0]     occ_r [FLUX];

  logic                 wr_s;
  logic                 free_s;
  logic                 load_s;
  logic [TAG_WIDTH-1:0] out_tag_s;
  logic [FLUX-1:0]      eligible_s;
  logic [FLUX-1:0]      grant_s;
  logic [TAG_WIDTH-1:0] grant_idx_s;
  logic [DW-1:0]        grant_payload_s;
  logic [WIDTH-1:0]     load_word_s;
  logic [FLUX-1:0]      inc_s;
  logic [FLUX-1:0]      dec_s;

  assign wr      = wr_s;
  assign dataout = out_data_r;

  // Transfer, free-slot and quota eligibility decode
  always_comb begin
    out_tag_s  = TAG_WIDTH'(tag_extract(word_t'(out_data_r), DW, TAG_WIDTH));
    wr_s       = out_valid_r & ~full;
    free_s     = ~out_valid_r | wr_s;
    eligible_s = '0;
    for (int i = 0; i < FLUX; i++) begin
      // The word in the output register is not yet in occ even when it is
      // leaving this cycle: its increment lands on the same edge as a new
      // load, so it must always count against its own flux.
      if (in_valid[i] &&
          ((int'(occ_r[i]) +
            ((out_valid_r && (int'(out_tag_s) == i)) ? 32'sd1 : 32'sd0)) < QUOTA)) begin
        eligible_s[i] = 1'b1;
      end else begin
        eligible_s[i] = 1'b0;
      end
    end
  end

  rr_grant #(
    .FLUX      (FLUX),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_rr_grant (
    .request   (eligible_s),
    .last      (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Accept decision and word assembly for the granted source
  always_comb begin
    grant_payload_s = in_data[int'(grant_idx_s)*DW +: DW];
    load_word_s     = WIDTH'(tag_insert(word_t'(grant_payload_s),
                                        word_t'(grant_idx_s), DW, TAG_WIDTH));
    // No acceptance while full (register must stay put) or during reset.
    load_s = free_s & ~full & ~rst & (|grant_s);
    if (load_s) begin
      in_ready = grant_s;
    end else begin
      in_ready = '0;
    end
  end

  // Output register: reload when free, otherwise hold
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      rr_ptr_r    <= TAG_WIDTH'(FLUX - 1);
    end else if (free_s) begin
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= load_word_s;
        rr_ptr_r    <= grant_idx_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Occupancy events: writes of each tag and non-empty reads of each flux
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    for (int i = 0; i < FLUX; i++) begin
      inc_s[i] = wr_s & (int'(out_tag_s) == i);
      dec_s[i] = rd[i] & ~empty[i] & (occ_r[i] != '0);
    end
  end

  // Per-flux occupancy counters, saturating at both ends
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FLUX; i++) begin
        occ_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FLUX; i++) begin
        if (inc_s[i] && !dec_s[i] && (int'(occ_r[i]) < QUOTA)) begin
          occ_r[i] <= occ_r[i] + OCC_W'(1);
        end else if (dec_s[i] && !inc_s[i]) begin
          occ_r[i] <= occ_r[i] - OCC_W'(1);
        end else begin
          occ_r[i] <= occ_r[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_flux_tag_arbiter.sv
// tb_flux_tag_arbiter
// Scoreboard bench for flux_tag_arbiter with WIDTH=8, FLUX=2, QUOTA=3.
// A cycle model predicts wr/in_ready each cycle and pushes the expected FIFO
// word when it predicts an acceptance; the word is popped and compared when
// the DUT asserts wr. The bench also models the FIFO fill per flux and drives
// the empty flags from it.
module tb_flux_tag_arbiter;

  localparam int WIDTH = 8;
  localparam int FLUX  = 2;
  localparam int QUOTA = 3;
  localparam int DW    = 7;

  logic               ck = 1'b0;
  logic               rst;
  logic [FLUX*DW-1:0] in_data;
  logic [FLUX-1:0]    in_valid;
  logic [FLUX-1:0]    in_ready;
  logic               full;
  logic [FLUX-1:0]    empty;
  logic [FLUX-1:0]    rd;
  logic               wr;
  logic [WIDTH-1:0]   dataout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit         m_ov;
  logic [7:0] m_data;
  int         m_ptr;
  int         m_cnt [FLUX];
  logic [7:0] exp_q [$];

  // Observations taken at the last sampled cycle
  int         wr_tags [$];
  int         wr_count;
  logic       obs_wr;
  logic [1:0] obs_rdy;
  logic [7:0] obs_dout;
  bit         seen;

  always #5 ck = ~ck;

  assign empty[0] = (m_cnt[0] == 0);
  assign empty[1] = (m_cnt[1] == 0);

  flux_tag_arbiter #(
    .WIDTH (WIDTH),
    .FLUX  (FLUX),
    .QUOTA (QUOTA)
  ) dut (
    .ck       (ck),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .full     (full),
    .empty    (empty),
    .rd       (rd),
    .wr       (wr),
    .dataout  (dataout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ov   = 1'b0;
    m_data = 8'h00;
    m_ptr  = FLUX - 1;
    for (int i = 0; i < FLUX; i++) m_cnt[i] = 0;
    exp_q.delete();
  endtask

  // Assert reset (possibly mid-cycle), check outputs are quiet, release
  // one cycle later aligned to posedge+1.
  task automatic reset_dut();
    rst      = 1'b1;
    in_valid = 2'b11;
    rd       = 2'b00;
    full     = 1'b0;
    in_data  = 14'h3FFF;
    #1;
    check_eq("rst_wr", wr, 1'b0);
    check_eq("rst_in_ready", in_ready, 2'b00);
    model_reset();
    @(posedge ck);
    @(posedge ck);
    #1;
    rst      = 1'b0;
    in_valid = 2'b00;
  endtask

  // One clock: compare at negedge, advance the model after posedge.
  task automatic tick();
    logic       m_wr;
    logic [1:0] m_rdy;
    int         idx;
    int         pend;
    int         gi;
    logic [7:0] w;
    @(negedge ck);
    m_wr  = m_ov && !full;
    m_rdy = 2'b00;
    gi    = 0;
    if ((!m_ov || m_wr) && !full) begin
      for (int k = 1; k <= FLUX; k++) begin
        idx  = (m_ptr + k) % FLUX;
        pend = (m_ov && (int'(m_data[7]) == idx)) ? 1 : 0;
        if (m_rdy == 2'b00 && in_valid[idx] && (m_cnt[idx] + pend < QUOTA)) begin
          m_rdy[idx] = 1'b1;
          gi = idx;
        end
      end
    end
    obs_wr   = wr;
    obs_rdy  = in_ready;
    obs_dout = dataout;
    check_eq("wr", wr, m_wr);
    check_eq("in_ready", in_ready, m_rdy);
    if (wr === 1'b1) begin
      wr_count++;
      wr_tags.push_back(int'(dataout[7]));
      check_eq("sb_has_entry", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check_eq("dataout", dataout, w);
      end
    end
    @(posedge ck);
    #1;
    for (int i = 0; i < FLUX; i++) begin
      if (rd[i] && m_cnt[i] > 0) m_cnt[i]--;
    end
    if (m_wr) m_cnt[m_data[7]]++;
    if (!m_ov || m_wr) begin
      if (m_rdy != 2'b00) begin
        w      = {gi[0], in_data[gi*DW +: DW]};
        m_data = w;
        m_ov   = 1'b1;
        m_ptr  = gi;
        exp_q.push_back(w);
      end else begin
        m_ov = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 2'b00; rd = 2'b00; full = 1'b0; in_data = '0;
    model_reset();
    reset_dut();

    // Both sources valid, consumer drains: tags alternate from 0, one per cycle
    wr_tags.delete();
    wr_count = 0;
    for (int c = 0; c < 8; c++) begin
      in_data  = 14'($urandom);
      in_valid = 2'b11;
      rd       = {m_cnt[1] > 0, m_cnt[0] > 0};
      tick();
    end
    check_eq("alt_count", wr_count, 7);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("alt_tag%0d", i), (i < wr_tags.size()) ? wr_tags[i] : -1, i % 2);
    end
    rd = 2'b00;

    // 0x85 held in the register while full is high for three cycles
    reset_dut();
    in_valid = 2'b10;
    in_data  = {7'h05, 7'h11};
    tick();
    in_valid = 2'b11;
    full     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("hold_dout", obs_dout, 8'h85);
    end
    full     = 1'b0;
    in_valid = 2'b00;
    tick();
    check_eq("release_wr", obs_wr, 1'b1);
    tick();

    // Quota of 3 for flux 0 with no reads, then one read frees one slot
    reset_dut();
    in_valid = 2'b01;
    wr_count = 0;
    for (int c = 0; c < 6; c++) begin
      in_data = 14'($urandom);
      tick();
    end
    check_eq("quota_writes", wr_count, 3);
    check_eq("quota_ready", obs_rdy, 2'b00);
    check_eq("quota_occ", dut.occ_r[0], 3);
    wr_count = 0;
    rd = 2'b01;
    tick();
    rd = 2'b00;
    for (int c = 0; c < 4; c++) tick();
    check_eq("quota_refill", wr_count, 1);

    // Read and write of flux 1 on the same edge at occ=2
    reset_dut();
    in_valid = 2'b10;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_data = 14'($urandom);
      if (!seen && m_cnt[1] == 2 && m_ov && m_data[7] == 1'b1) begin
        rd = 2'b10;
        tick();
        rd   = 2'b00;
        seen = 1'b1;
        check_eq("coincide_occ", dut.occ_r[1], 2);
      end else begin
        tick();
      end
    end
    check_eq("coincide_seen", seen, 1'b1);

    // Flux 1 payload 0x2A appears as 0xAA one cycle after acceptance
    reset_dut();
    in_valid = 2'b10;
    in_data  = {7'h2A, 7'h55};
    tick();
    check_eq("aa_ready", obs_rdy, 2'b10);
    in_valid = 2'b00;
    tick();
    check_eq("aa_wr", obs_wr, 1'b1);
    check_eq("aa_dout", obs_dout, 8'hAA);

    // Reset with a word pending: discarded, then source 0 wins first
    in_valid = 2'b01;
    in_data  = 14'($urandom);
    tick();
    in_valid = 2'b00;
    full     = 1'b1;
    tick();
    #2;
    reset_dut();
    in_valid = 2'b11;
    in_data  = 14'($urandom);
    tick();
    check_eq("first_after_rst", obs_rdy, 2'b01);
    in_valid = 2'b00;
    tick();
    check_eq("post_rst_wr", obs_wr, 1'b1);
    check_eq("post_rst_tag", obs_dout[7], 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
